// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L1->L2 arbiter: memory operation encoding, arbiter FSM
// states, port count and a saturating counter helper.
package l2_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam int ARB_NUM_PORTS = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/l2_arb_rr_picker.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port that was
// not granted last wins. Purely combinational, one-hot (or zero) output.
module l2_arb_rr_picker
  import l2_arbiter_pkg::*;
(
  input  logic [ARB_NUM_PORTS-1:0] req_i,
  input  logic                     last_gnt_i,
  output logic [ARB_NUM_PORTS-1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) pick_o = last_gnt_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between icache (port 0) and dcache (port 1) for the single
// L2 port; grant held across bursts, forced hand-off every BURST_WORDS responses.
// Optional perf counters are built when L2_ARB_PERF_EN is defined.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BURST_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   p0_req_address,
  input  memory_operation_e p0_req_type,
  input  logic              p0_req_valid,
  input  logic [XLEN-1:0]   p0_word_to_store,
  output logic [XLEN-1:0]   p0_fetched_word,
  output logic              p0_fetched_word_valid,
  input  logic [XLEN-1:0]   p1_req_address,
  input  memory_operation_e p1_req_type,
  input  logic              p1_req_valid,
  input  logic [XLEN-1:0]   p1_word_to_store,
  output logic [XLEN-1:0]   p1_fetched_word,
  output logic              p1_fetched_word_valid,
  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_fetched_word_valid
`ifdef L2_ARB_PERF_EN
  ,
  output logic [31:0]       perf_gnt0_cnt,
  output logic [31:0]       perf_gnt1_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int BW = $clog2(BURST_WORDS + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_WORDS - 1);

  arb_state_e               state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic                     last_gnt_q, last_gnt_d;
  logic [ARB_NUM_PORTS-1:0] pick;
  logic                     own_valid, other_valid;

  l2_arb_rr_picker u_picker (
    .req_i      ({p1_req_valid, p0_req_valid}),
    .last_gnt_i (last_gnt_q),
    .pick_o     (pick)
  );

  assign own_valid   = (state_q == ARB_GNT1) ? p1_req_valid : p0_req_valid;
  assign other_valid = (state_q == ARB_GNT1) ? p0_req_valid : p1_req_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      beat_q     <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ARB_IDLE: begin
        beat_d = '0;
        if (pick[0]) begin
          state_d    = ARB_GNT0;
          last_gnt_d = 1'b0;
        end else if (pick[1]) begin
          state_d    = ARB_GNT1;
          last_gnt_d = 1'b1;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (!own_valid) begin
          state_d = ARB_IDLE;
          beat_d  = '0;
        end else if (l2_fetched_word_valid) begin
          // Hand-off only on a response edge so no outstanding request is lost.
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (other_valid) begin
              state_d    = (state_q == ARB_GNT0) ? ARB_GNT1 : ARB_GNT0;
              last_gnt_d = (state_q == ARB_GNT0);
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    l2_req_valid     = 1'b0;
    l2_req_address   = '0;
    l2_req_type      = MEM_NOP;
    l2_word_to_store = '0;
    case (state_q)
      ARB_GNT0: begin
        l2_req_valid     = p0_req_valid;
        l2_req_address   = p0_req_address;
        l2_req_type      = p0_req_type;
        l2_word_to_store = p0_word_to_store;
      end
      ARB_GNT1: begin
        l2_req_valid     = p1_req_valid;
        l2_req_address   = p1_req_address;
        l2_req_type      = p1_req_type;
        l2_word_to_store = p1_word_to_store;
      end
      default: ;
    endcase
  end

  assign p0_fetched_word       = l2_fetched_word;
  assign p1_fetched_word       = l2_fetched_word;
  assign p0_fetched_word_valid = l2_fetched_word_valid & (state_q == ARB_GNT0);
  assign p1_fetched_word_valid = l2_fetched_word_valid & (state_q == ARB_GNT1);

`ifdef L2_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_stall_q;
  logic        gnt0_entry, gnt1_entry, stall;

  assign gnt0_entry = (state_d == ARB_GNT0) && (state_q != ARB_GNT0);
  assign gnt1_entry = (state_d == ARB_GNT1) && (state_q != ARB_GNT1);
  assign stall      = (p0_req_valid && state_q != ARB_GNT0) ||
                      (p1_req_valid && state_q != ARB_GNT1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (gnt0_entry) perf_gnt0_q  <= sat_inc32(perf_gnt0_q);
      if (gnt1_entry) perf_gnt1_q  <= sat_inc32(perf_gnt1_q);
      if (stall)      perf_stall_q <= sat_inc32(perf_stall_q);
    end
  end

  assign perf_gnt0_cnt  = perf_gnt0_q;
  assign perf_gnt1_cnt  = perf_gnt1_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
